// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 matrix keypad scanner.
// Key map layout: bit 4*row+col is the key at (row, col).
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;

    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    function automatic logic [3:0] lowest_set(input logic [KP_KEYS-1:0] map);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = KP_KEYS - 1; i >= 0; i--) begin
            if (map[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Two columns sharing two pressed rows form a rectangle; the fourth corner may be a ghost.
    function automatic logic is_ghost(input logic [KP_KEYS-1:0] map);
        logic found;
        int   shared;
        found = 1'b0;
        for (int i = 0; i < KP_COLS; i++) begin
            for (int j = i + 1; j < KP_COLS; j++) begin
                shared = 0;
                for (int r = 0; r < KP_ROWS; r++) begin
                    if (map[key_index(2'(r), 2'(i))] && map[key_index(2'(r), 2'(j))]) begin
                        shared = shared + 1;
                    end
                end
                if (shared >= 2) begin
                    found = 1'b1;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Frame-level debouncer: publishes the key map once DEBOUNCE_CNT identical frames are seen.
// Define KP_GHOST_MASK_EN to reject ambiguous (rectangle) frames.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               i_frame_done,
    input  logic [KP_KEYS-1:0] i_frame,
    output logic [KP_KEYS-1:0] o_val,
    output logic               o_valid,
    output logic               o_any,
    output logic [3:0]         o_code
);

    localparam int            SW         = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_CNT - 1);

    logic [KP_KEYS-1:0] r_prev;
    logic [SW-1:0]      r_stable;
    logic [KP_KEYS-1:0] r_val;
    logic               r_valid;
    logic               r_any;
    logic [3:0]         r_code;

    logic               w_ghost;
    logic               w_same;
    logic               w_publish;
    logic [SW-1:0]      w_stable_next;

`ifdef KP_GHOST_MASK_EN
    assign w_ghost = is_ghost(i_frame);
`else
    assign w_ghost = 1'b0;
`endif

    // An ambiguous frame never counts as a repeat, so it also restarts qualification.
    assign w_same = (i_frame == r_prev) && !w_ghost;

    always_comb begin
        w_stable_next = '0;
        if (w_same) begin
            w_stable_next = (r_stable == STABLE_MAX) ? r_stable : r_stable + 1'b1;
        end
    end

    assign w_publish = (w_stable_next == STABLE_MAX) && (i_frame != r_val) && !w_ghost;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev   <= '0;
            r_stable <= '0;
        end else if (i_frame_done) begin
            r_prev   <= i_frame;
            r_stable <= w_stable_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_val   <= '0;
            r_valid <= 1'b0;
            r_any   <= 1'b0;
            r_code  <= 4'd0;
        end else begin
            r_valid <= 1'b0;
            if (i_frame_done && w_publish) begin
                r_val   <= i_frame;
                r_valid <= 1'b1;
                r_any   <= |i_frame;
                r_code  <= lowest_set(i_frame);
            end
        end
    end

    assign o_val   = r_val;
    assign o_valid = r_valid;
    assign o_any   = r_any;
    assign o_code  = r_code;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner top: row synchroniser, column scan timing and frame assembly.
// Optional ghost rejection in the debouncer is enabled with KP_GHOST_MASK_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  kp_row,
    output logic [3:0]  kp_col,
    output logic [15:0] kp_val,
    output logic        kp_valid,
    output logic        kp_any,
    output logic [3:0]  kp_code
);

    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [KP_ROWS-1:0] r_row_meta;
    logic [KP_ROWS-1:0] r_row_sync;
    logic [DW-1:0]      r_div;
    logic [1:0]         r_col_idx;
    logic [3:0]         r_col_drv;
    logic [KP_KEYS-1:0] r_frame;

    logic [KP_ROWS-1:0] w_rows_pressed;
    logic               w_sample;
    logic               w_frame_done;
    logic [1:0]         w_col_next;
    logic [KP_KEYS-1:0] w_frame_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= kp_row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_rows_pressed = ~r_row_sync;
    assign w_sample       = (r_div == DIV_LAST);
    assign w_col_next     = r_col_idx + 2'd1;
    assign w_frame_done   = w_sample && (r_col_idx == 2'd3);

    // Column drive is registered from the next index so the pins never glitch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
            r_col_drv <= 4'b1110;
        end else if (w_sample) begin
            r_div     <= '0;
            r_col_idx <= w_col_next;
            r_col_drv <= ~(4'b0001 << w_col_next);
        end else begin
            r_div     <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_frame_next = r_frame;
        for (int r = 0; r < KP_ROWS; r++) begin
            w_frame_next[key_index(2'(r), r_col_idx)] = w_rows_pressed[r];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame <= '0;
        end else if (w_sample) begin
            r_frame <= w_frame_next;
        end
    end

    assign kp_col = r_col_drv;

    keypad_debouncer #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debouncer (
        .clock        (clock),
        .reset        (reset),
        .i_frame_done (w_frame_done),
        .i_frame      (w_frame_next),
        .o_val        (kp_val),
        .o_valid      (kp_valid),
        .o_any        (kp_any),
        .o_code       (kp_code)
    );

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines.
- Debounces whole scan frames and publishes a 16-bit pressed-key map `kp_val`, plus a change strobe and a priority key code.
- `kp_val` is the producer side of the keypad value bus consumed by the dot-matrix display block.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven; rows are sampled on the last cycle of the window (min 4).
- DEBOUNCE_CNT, 4, consecutive identical frames required before `kp_val` updates (min 1).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- kp_row  input  4  keypad row lines, active-low (pulled up), asynchronous to clock.
- kp_col  output  4  column drive, active-low one-hot.
- kp_val  output  16  debounced key map; bit 4*r+c = 1 means the key at row r, column c is pressed.
- kp_valid  output  1  one-cycle pulse when `kp_val` changes.
- kp_any  output  1  high when `kp_val` != 0.
- kp_code  output  4  index of the lowest set bit of `kp_val`; 0 when none.

Behaviour:
- Reset (async, active-high) sets:
  - `kp_col` = 4'b1110, column index = 0, division counter = 0.
  - raw frame, previous frame and stable counter = 0.
  - `kp_val` = 0, `kp_valid` = 0, `kp_any` = 0, `kp_code` = 0.
- Row synchronisation: `kp_row` passes through a 2-FF synchroniser (reset value 4'b1111). The sampled value is the inverted synchronised rows.
- Column scan:
  - Division counter runs 0..SCAN_DIV-1.
  - When the counter = SCAN_DIV-1: store the sampled rows into the raw frame bits for the current column c (bits 4*r+c, r = 0..3), then advance the column index (3 wraps to 0).
  - `kp_col` changes in the cycle after the sample and is registered, so it is glitch-free.
  - Frame period = 4*SCAN_DIV cycles.
- Frame end, on the column-3 sample cycle (the frame includes the column-3 sample written that cycle):
  - If frame == previous frame, the stable counter increments, saturating at DEBOUNCE_CNT-1. Otherwise it clears to 0.
  - previous frame <= frame.
  - If the stable counter (post-update) == DEBOUNCE_CNT-1 and frame != `kp_val`:
    - `kp_val` <= frame in the next cycle, with `kp_valid` = 1 for exactly that cycle.
    - `kp_any` and `kp_code` update in the same cycle as `kp_val` (registered from frame).
- DEBOUNCE_CNT = 1: every differing frame updates `kp_val`.
- Latency: a clean press first appears DEBOUNCE_CNT frames after the first frame containing it, plus 1 cycle. Release behaves the same.
- Bounce: any differing frame restarts the count, and `kp_val` holds its old value.
- Multiple keys: every pressed key bit is reported. `kp_code` gives the lowest index.
- Reset mid-frame: scanning restarts at column 0. Partial frame data is discarded.

Optional Feature:
- Macro: KP_GHOST_MASK_EN.
- Defined: a frame is ambiguous if any two columns share two or more pressed rows, i.e. popcount(colmask_i & colmask_j) >= 2 for some i < j. An ambiguous frame:
  - counts as differing (stable counter clears);
  - never updates `kp_val`;
  - is stored as previous frame.
- Not defined: no ghost check; rectangles are reported as-is.

Decomposition:
- Package `keypad_pkg`:
  - constants KP_ROWS = 4, KP_COLS = 4, KP_KEYS = 16;
  - a function mapping (row, col) to a bit index;
  - a function returning the lowest set index of a 16-bit map.
- Sub-module `keypad_debouncer`: frame compare, stable counter, ghost check, `kp_val`/`kp_valid`/`kp_any`/`kp_code` registers.
- Top level owns the synchroniser, division counter and column drive.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, frame = 16 cycles):
- Reset held, then released with no keys -> `kp_col` cycles 1110, 1101, 1011, 0111 every 4 cycles; `kp_val` stays 0; `kp_valid` never pulses.
- Hold key r=1,c=2 steady -> `kp_val` = 16'h0040, `kp_code` = 6, `kp_any` = 1, a single `kp_valid` pulse after 3 frames; release -> `kp_val` = 0 after 3 frames with one pulse.
- Toggle key r=0,c=0 every frame for 6 frames, then hold -> no update during toggling; `kp_val` = 16'h0001 only 3 stable frames after toggling stops.
- Press keys 0 and 15 together -> `kp_val` = 16'h8001, `kp_code` = 0.
- Assert reset mid-column 2 with a key held -> all outputs return to reset values immediately (async); scanning restarts at column 0 and the key re-qualifies after 3 full frames.
- With KP_GHOST_MASK_EN: press (0,0),(0,1),(1,0) so the matrix reads the (1,1) ghost -> `kp_val` holds its previous value and no pulse. Without it -> `kp_val` = 16'h0033.
